// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, packet
// layouts (field bit positions are fixed by the packed struct member
// order, MSB first) and the stage FSM encoding.
package mem_stage_pkg;

  localparam int ES_BUS_W  = 71;
  localparam int WS_BUS_W  = 70;
  localparam int CHE_BUS_W = 39;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } ms_state_e;

  // {res_from_mem[70], rf_we[69], dest[68:64], pc[63:32], alu_result[31:0]}
  typedef struct packed {
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] alu_result;
  } es_to_ms_t;

  // {rf_we[69], dest[68:64], pc[63:32], final_result[31:0]}
  typedef struct packed {
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] final_result;
  } ms_to_ws_t;

  // {ms_rf_we[38], ms_dest[37:33], ms_fwd_valid[32], ms_fwd_data[31:0]}
  typedef struct packed {
    logic        rf_we;
    logic [4:0]  dest;
    logic        fwd_valid;
    logic [31:0] fwd_data;
  } ms_to_che_t;

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for the load response, picks the writeback value.
// Latency: non-load valid one cycle after accept; load valid one cycle after data_sram_data_ok.
// Backpressure: holds packet stable while ws_allow_in=0; ms_allow_in only when empty or departing this cycle.
//
// Ports:
//   clk, rst                 core clock, asynchronous active-high reset
//   es_to_ms_valid/_bus      incoming packet from execute, accepted when ms_allow_in=1
//   ms_allow_in              stage can take a packet this cycle
//   data_sram_data_ok/_rdata load response pulse and data
//   ws_allow_in              writeback stage accepts the outgoing packet
//   ms_to_ws_valid/_bus      outgoing packet to writeback
//   ms_to_che_bus            destination/bypass info for the hazard checker
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ES_TO_MS_WD  = ES_BUS_W,
  parameter int MS_TO_WS_WD  = WS_BUS_W,
  parameter int MS_TO_CHE_WD = CHE_BUS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    es_to_ms_valid,
  input  logic [ES_TO_MS_WD-1:0]  es_to_ms_bus,
  output logic                    ms_allow_in,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    ws_allow_in,
  output logic                    ms_to_ws_valid,
  output logic [MS_TO_WS_WD-1:0]  ms_to_ws_bus,
  output logic [MS_TO_CHE_WD-1:0] ms_to_che_bus
);

  ms_state_e   ms_state_q, ms_state_d;
  es_to_ms_t   r_bus_q, r_bus_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  es_to_ms_t   es_pkt;
  ms_to_ws_t   ws_pkt;
  ms_to_che_t  che_pkt;
  logic        accept;
  logic [31:0] final_result;

  assign es_pkt = es_to_ms_t'(es_to_ms_bus);

  // Only READY looks at ws_allow_in, so a departing slot can refill in the
  // same cycle without a bubble.
  assign ms_allow_in = (ms_state_q == EMPTY) ||
                       ((ms_state_q == READY) && ws_allow_in);
  assign accept      = es_to_ms_valid && ms_allow_in;

  always_comb begin
    ms_state_d  = ms_state_q;
    r_bus_d     = r_bus_q;
    rdata_buf_d = rdata_buf_q;

    unique case (ms_state_q)
      EMPTY: ;
      WAIT: begin
        // Response is only taken while waiting; a data_ok in EMPTY or
        // READY is spurious and leaves rdata_buf alone.
        if (data_sram_data_ok) begin
          rdata_buf_d = data_sram_rdata;
          ms_state_d  = READY;
        end
      end
      READY: begin
        if (ws_allow_in) begin
          ms_state_d = EMPTY;
        end
      end
      default: ms_state_d = EMPTY;
    endcase

    // Accept overrides the departure above; a data_ok in the accept cycle
    // is ignored since the state is not yet WAIT.
    if (accept) begin
      r_bus_d    = es_pkt;
      ms_state_d = es_pkt.res_from_mem ? WAIT : READY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_state_q  <= EMPTY;
      r_bus_q     <= '0;
      rdata_buf_q <= '0;
    end else begin
      ms_state_q  <= ms_state_d;
      r_bus_q     <= r_bus_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  assign final_result = r_bus_q.res_from_mem ? rdata_buf_q : r_bus_q.alu_result;

  always_comb begin
    ws_pkt              = '0;
    ws_pkt.rf_we        = r_bus_q.rf_we;
    ws_pkt.dest         = r_bus_q.dest;
    ws_pkt.pc           = r_bus_q.pc;
    ws_pkt.final_result = final_result;

    // In WAIT the checker sees a pending write with no forwardable data,
    // which makes it stall dependents.
    che_pkt           = '0;
    che_pkt.rf_we     = r_bus_q.rf_we && (ms_state_q != EMPTY);
    che_pkt.dest      = r_bus_q.dest;
    che_pkt.fwd_valid = (ms_state_q == READY);
    che_pkt.fwd_data  = final_result;
  end

  assign ms_to_ws_valid = (ms_state_q == READY);
  assign ms_to_ws_bus   = ws_pkt;
  assign ms_to_che_bus  = che_pkt;

endmodule
